// File: rtl/sr_pkg.sv
// Shared definitions for the SR-flop bank driver: FSM states, 2-bit S/R
// excitation codes and the width helper for the changed-bit counter.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    HOLD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } sr_state_e;

  // {S,R} codes as presented to one flop
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RST     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sr_excite_driver_if.sv
// Target handshake plus flop-bank excitation/readback bundle for sr_excite_driver.
// The slave modport is the driver itself; master is the controller/bank side.
interface sr_excite_driver_if #(
  parameter int WIDTH = 8
);
  import sr_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic [CW-1:0]    chg_cnt;
  logic             err;

  modport slave (
    input  tgt_valid, tgt_data, q_in,
    output tgt_ready, s_out, r_out, busy, done, chg_cnt, err
  );

  modport master (
    output tgt_valid, tgt_data, q_in,
    input  tgt_ready, s_out, r_out, busy, done, chg_cnt, err
  );

endinterface

// File: rtl/sr_excite_bit.sv
// Per-bit S/R excitation: set bits rising from the shadow value, reset bits
// falling from it, hold otherwise.
module sr_excite_bit
  import sr_pkg::*;
(
  input  logic tgt,
  input  logic shadow,
  output logic s,
  output logic r
);

  logic [1:0] code_s;

  // Map the wanted transition onto an SR code
  always_comb begin
    code_s = SR_HOLD;
    case ({tgt, shadow})
      2'b10:   code_s = SR_SET;
      2'b01:   code_s = SR_RST;
      default: code_s = SR_HOLD;
    endcase
  end

  // The guard keeps the forbidden code off the bank even if the table is edited later
  assign s = (code_s != SR_ILLEGAL) & code_s[1];
  assign r = (code_s != SR_ILLEGAL) & code_s[0];

endmodule

// File: rtl/sr_excite_driver.sv
// Write-side driver for a bank of clocked SR flops: one-cycle excitation pulse,
// settle window, optional Q readback check (SR_READBACK_CHECK_EN).
module sr_excite_driver
  import sr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_excite_driver_if.slave    bus
);

  localparam int         CW        = cnt_width(WIDTH);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

`ifdef SR_READBACK_CHECK_EN
  localparam sr_state_e POST_SETTLE = CHECK;
`else
  localparam sr_state_e POST_SETTLE = DONE;
`endif
  localparam sr_state_e POST_DRIVE = (SETTLE > 0) ? HOLD : POST_SETTLE;

  sr_state_e        state_r;
  logic [WIDTH-1:0] shadow_r;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] s_out_r;
  logic [WIDTH-1:0] r_out_r;
  logic [WIDTH-1:0] s_exc_s;
  logic [WIDTH-1:0] r_exc_s;
  logic [WIDTH-1:0] diff_s;
  logic [CW-1:0]    pop_s;
  logic [CW-1:0]    chg_r;
  logic [3:0]       settle_cnt_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;

  assign accept_s = bus.tgt_valid & ready_r;
  assign diff_s   = bus.tgt_data ^ shadow_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_excite_bit u_bit (
      .tgt    (bus.tgt_data[i]),
      .shadow (shadow_r[i]),
      .s      (s_exc_s[i]),
      .r      (r_exc_s[i])
    );
  end

  // Number of bits the offered target would change
  always_comb begin
    pop_s = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pop_s = pop_s + CW'(diff_s[i]);
    end
  end

`ifdef SR_READBACK_CHECK_EN
  logic err_r;
  assign bus.err = err_r;
`else
  logic unused_q_s;
  assign unused_q_s = ^bus.q_in;
  assign bus.err    = 1'b0;
`endif

  // Transaction FSM; every output is a register so the bank never sees glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      s_out_r      <= {WIDTH{1'b0}};
      r_out_r      <= {WIDTH{1'b0}};
      chg_r        <= {CW{1'b0}};
      shadow_r     <= {WIDTH{1'b0}};
      tgt_r        <= {WIDTH{1'b0}};
      settle_cnt_r <= 4'd0;
`ifdef SR_READBACK_CHECK_EN
      err_r        <= 1'b0;
`endif
    end else begin
      done_r  <= 1'b0;
      s_out_r <= {WIDTH{1'b0}};
      r_out_r <= {WIDTH{1'b0}};
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            tgt_r   <= bus.tgt_data;
            s_out_r <= s_exc_s;
            r_out_r <= r_exc_s;
            chg_r   <= pop_s;
            state_r <= DRIVE;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        DRIVE: begin
          shadow_r     <= tgt_r;
          settle_cnt_r <= SETTLE_LD;
          state_r      <= POST_DRIVE;
          done_r       <= (POST_DRIVE == DONE);
        end
        HOLD: begin
          if (settle_cnt_r == 4'd0) begin
            state_r <= POST_SETTLE;
            done_r  <= (POST_SETTLE == DONE);
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        CHECK: begin
`ifdef SR_READBACK_CHECK_EN
          if (bus.q_in != tgt_r) begin
            err_r <= 1'b1;
          end
`endif
          state_r <= DONE;
          done_r  <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tgt_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.s_out     = s_out_r;
  assign bus.r_out     = r_out_r;
  assign bus.chg_cnt   = chg_r;

endmodule

// File: tb/tb_sr_excite_driver.sv
// Randomized self-checking bench: two drivers (SETTLE=1 and SETTLE=0), each on
// a modelled SR flop bank, checked against a transaction-level reference.
module tb_sr_excite_driver;
  import sr_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SR_READBACK_CHECK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_excite_driver_if #(.WIDTH(W)) ifa ();
  sr_excite_driver_if #(.WIDTH(W)) ifb ();

  sr_excite_driver #(.WIDTH(W), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sr_excite_driver #(.WIDTH(W), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic          tv     [2];
  logic [W-1:0]  td     [2];
  logic [W-1:0]  q_bank [2];
  logic          stuck0 [2];
  logic          rdy    [2];
  logic          bz     [2];
  logic          dn     [2];
  logic          er     [2];
  logic [W-1:0]  so     [2];
  logic [W-1:0]  ro     [2];
  logic [CW-1:0] cc     [2];

  assign ifa.tgt_valid = tv[0];
  assign ifa.tgt_data  = td[0];
  assign ifa.q_in      = q_bank[0] & ~(W'(stuck0[0]));
  assign ifb.tgt_valid = tv[1];
  assign ifb.tgt_data  = td[1];
  assign ifb.q_in      = q_bank[1] & ~(W'(stuck0[1]));

  assign rdy[0] = ifa.tgt_ready;  assign rdy[1] = ifb.tgt_ready;
  assign bz[0]  = ifa.busy;       assign bz[1]  = ifb.busy;
  assign dn[0]  = ifa.done;       assign dn[1]  = ifb.done;
  assign er[0]  = ifa.err;        assign er[1]  = ifb.err;
  assign so[0]  = ifa.s_out;      assign so[1]  = ifb.s_out;
  assign ro[0]  = ifa.r_out;      assign ro[1]  = ifb.r_out;
  assign cc[0]  = ifa.chg_cnt;    assign cc[1]  = ifb.chg_cnt;

  // Clocked SR flop bank: S sets, R resets, neither holds
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_bank[0] <= '0;
      q_bank[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) q_bank[k] <= (q_bank[k] & ~ro[k]) | so[k];
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // The forbidden S=R=1 code must never appear on either bank
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) chk_eq("no_illegal", 32'(so[k] & ro[k]), 32'd0);
    end
  end

  // Reference state: what the bank should hold and whether err should be set
  logic [W-1:0] ref_sh    [2];
  logic         err_ref   [2];
  int           last_done [2];
  bit           prev_keep [2];

  task automatic txn(input int k, input logic [W-1:0] tgt, input bit keep);
    int settle, lat, waited, done_win, n_done, acc_edge;
    logic [W-1:0] es, ers;
    int ec;
    settle = (k == 0) ? 1 : 0;
    lat    = 2 + settle + RB;
    es     = tgt & ~ref_sh[k];
    ers    = ~tgt & ref_sh[k];
    ec     = $countones(tgt ^ ref_sh[k]);
    td[k]  = tgt;
    tv[k]  = 1'b1;
    waited = 0;
    while (!rdy[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk_eq("ready_wait", 32'(rdy[k]), 32'd1);
    @(negedge clk);
    acc_edge = edge_cnt;
    if (keep && prev_keep[k]) chk_eq("b2b_gap", 32'(acc_edge - last_done[k]), 32'd1);
    if (!keep) tv[k] = 1'b0;
    td[k] = W'($urandom);
    chk_eq("drive_s", 32'(so[k]), 32'(es));
    chk_eq("drive_r", 32'(ro[k]), 32'(ers));
    chk_eq("chg_cnt", 32'(cc[k]), 32'(ec));
    chk_eq("busy_drive", 32'(bz[k]), 32'd1);
    chk_eq("ready_busy", 32'(rdy[k]), 32'd0);
    done_win = -1;
    n_done   = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == lat) td[k] = W'($urandom);
      chk_eq("s_after", 32'(so[k]), 32'd0);
      chk_eq("r_after", 32'(ro[k]), 32'd0);
      if (dn[k]) begin
        n_done++;
        if (done_win < 0) done_win = i;
      end
    end
    err_ref[k] = err_ref[k] | ((RB == 1) && stuck0[k] && tgt[0]);
    ref_sh[k]  = tgt;
    chk_eq("latency", 32'(done_win + 1), 32'(lat));
    chk_eq("done_count", 32'(n_done), 32'd1);
    chk_eq("ready_idle", 32'(rdy[k]), 32'd1);
    chk_eq("busy_idle", 32'(bz[k]), 32'd0);
    chk_eq("chg_hold", 32'(cc[k]), 32'(ec));
    chk_eq("err", 32'(er[k]), 32'(err_ref[k]));
    chk_eq("bank_q", 32'(q_bank[k]), 32'(tgt));
    last_done[k] = acc_edge + lat;
    prev_keep[k] = keep;
  endtask

  task automatic reset_ref();
    for (int k = 0; k < 2; k++) begin
      ref_sh[k]    = '0;
      err_ref[k]   = 1'b0;
      last_done[k] = 0;
      prev_keep[k] = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input int k);
    chk_eq("rst_ready", 32'(rdy[k]), 32'd1);
    chk_eq("rst_busy",  32'(bz[k]),  32'd0);
    chk_eq("rst_done",  32'(dn[k]),  32'd0);
    chk_eq("rst_s",     32'(so[k]),  32'd0);
    chk_eq("rst_r",     32'(ro[k]),  32'd0);
    chk_eq("rst_chg",   32'(cc[k]),  32'd0);
    chk_eq("rst_err",   32'(er[k]),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t;
    for (int k = 0; k < 2; k++) begin
      tv[k] = 1'b0; td[k] = '0; stuck0[k] = 1'b0;
    end
    reset_ref();
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst = 1'b0;
    @(negedge clk);

    // Directed: set, full flip, repeat of the same target
    txn(0, 8'hA5, 1'b0);
    txn(0, 8'h5A, 1'b0);
    txn(0, 8'h5A, 1'b0);

    // Random targets on both drivers, with occasional repeats of the shadow
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        t = W'($urandom);
        if ($urandom_range(3) == 0) t = ref_sh[k];
        txn(k, t, 1'b0);
      end
    end

    // Back-to-back with tgt_valid held high on the SETTLE=0 driver
    txn(1, 8'h01, 1'b1);
    txn(1, 8'h03, 1'b1);
    txn(1, 8'h07, 1'b1);
    tv[1] = 1'b0;
    @(negedge clk);

    // Readback fault: bit 0 stuck at 0, then good transactions
    stuck0[0] = 1'b1;
    txn(0, 8'h01, 1'b0);
    txn(0, 8'hF0, 1'b0);
    stuck0[0] = 1'b0;
    txn(0, 8'h0F, 1'b0);

    // Abort during HOLD
    td[0] = 8'hFF;
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    @(negedge clk);
    chk_eq("abort_busy_before", 32'(bz[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals(0);
    @(negedge clk);
    rst = 1'b0;
    reset_ref();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("abort_no_done", 32'(dn[0]), 32'd0);
    end
    txn(0, 8'h3C, 1'b0);
    txn(1, 8'h81, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_excite_driver.md
# sr_excite_driver

Write-side driver for a bank of clocked SR flip-flops. It accepts a target bit vector over a valid/ready handshake and derives the per-bit S/R excitation from a shadow copy of the bank state. It drives the excitation for exactly one clock, waits a settle window, and optionally reads Q back to confirm the update. It never emits the forbidden S=R=1 code, and sits between control logic and any SR-flop register bank.

## Interface
Parameters:
- WIDTH, 8, number of SR flops in the driven bank (1..32).
- SETTLE, 1, idle cycles after the drive pulse before completion (0..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- tgt_valid  in  1  target vector offered.
- tgt_ready  out  1  block can accept a target (high only in IDLE).
- tgt_data  in  WIDTH  desired next Q of the bank.
- s_out  out  WIDTH  S inputs to the flop bank.
- r_out  out  WIDTH  R inputs to the flop bank.
- q_in  in  WIDTH  Q readback from the flop bank (used only with readback).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- chg_cnt  out  $clog2(WIDTH+1)  number of bits changed by the last transaction.
- err  out  1  sticky readback mismatch flag.

## Operation
- Excitation per bit: S = tgt & ~shadow, R = ~tgt & shadow. Unchanged bits get 00 (hold). S&R is always 0 by construction.
- The shadow register mirrors the bank. It resets to 0, which matches the flop power-up value of Q=0, and loads tgt_data at DRIVE.
- FSM states: IDLE, DRIVE, HOLD, CHECK, DONE.
  - IDLE: tgt_ready=1. On tgt_valid&tgt_ready, latch tgt_data, compute the excitation and chg_cnt (popcount of tgt^shadow), then go to DRIVE.
  - DRIVE: s_out/r_out present the excitation for exactly one cycle. Next state is HOLD if SETTLE>0, otherwise CHECK (or DONE when readback is compiled out).
  - HOLD: s_out=r_out=0. A down-counter loaded with SETTLE-1 runs; exit to CHECK (or DONE) when it reaches 0.
  - CHECK: compare q_in with the latched target. On mismatch set err, which stays set until rst. Go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in every state except IDLE.
- A target equal to the shadow is still a full transaction: all-zero excitation and chg_cnt=0.
- tgt_data is ignored outside the accept cycle. tgt_valid held high starts back-to-back transactions, each separated by the IDLE cycle.

## Timing
- Reset values: tgt_ready=1, busy=0, done=0, s_out=0, r_out=0, chg_cnt=0, err=0, shadow=0, state=IDLE.
- rst asserted mid-transaction aborts immediately: the excitation drops to 0 asynchronously and no done pulse is produced. rst must be applied together with the flop bank's own initialisation so that the shadow and the bank agree.
- Accept on edge T. DRIVE occupies cycle T..T+1, and the bank captures the new Q at edge T+1.
- HOLD occupies SETTLE cycles. CHECK samples q_in one cycle after HOLD, which is at least one full cycle after capture.
- Transaction latency from accept to the done pulse:
  - with readback: 3+SETTLE cycles.
  - without readback: 2+SETTLE cycles.
- The next accept can occur no earlier than one cycle after done.

## Configuration
- SR_READBACK_CHECK_EN:
  - Defined: the CHECK state exists, q_in is compared, and err is sticky on mismatch.
  - Undefined: CHECK is removed from the FSM, q_in is unused, err is tied to 0, and latency drops by one cycle.

## Structure
- Shared package sr_pkg contains:
  - the state enum (IDLE, DRIVE, HOLD, CHECK, DONE);
  - the 2-bit SR code constants (HOLD=00, RST=01, SET=10, ILLEGAL=11);
  - the popcount width function.
- One sub-module, sr_excite_bit: per-bit combinational excitation (tgt, shadow → s, r), instantiated WIDTH times.
- The FSM, settle counter, shadow register and popcount live in the top module.

## Test plan
- Reset, then target 8'hA5 with SETTLE=1 → single DRIVE cycle with s_out=A5, r_out=00; chg_cnt=4; done at accept+4; bench bank Q=A5; err=0.
- Next target 8'h5A → s_out=5A and r_out=A5 for one cycle; chg_cnt=8; no bit ever has S=R=1.
- Repeat target 8'h5A → s_out=r_out=00; chg_cnt=0; done still pulses at accept+4.
- Assert rst during HOLD → outputs return to reset values immediately; no done pulse; the next accept works from shadow=0.
- With SR_READBACK_CHECK_EN defined, force q_in bit 0 stuck at 0 and target 8'h01 → err=1 after CHECK and stays set through later good transactions. With the macro undefined → err stays 0 and latency is accept+3.
- SETTLE=0 with tgt_valid held high and targets 01, 03, 07 → DRIVE is followed directly by CHECK; transactions run back-to-back with one IDLE cycle between done and the next accept.
